// File: rtl/bus_ram_pkg.sv
// Shared types and constants for the bus_ram_emu slow-RAM bus emulator.
package bus_ram_pkg;

  typedef enum logic [1:0] {
    LATCH,
    WAIT,
    DONE
  } state_t;

  localparam logic [15:0] VEC_NMI_LO    = 16'hFFFA;
  localparam logic [15:0] VEC_RST_LO    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_LO    = 16'hFFFE;
  localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/bus_ram_emu_if.sv
// CPU <-> memory bus bundle: the CPU drives address/direction/data, memory answers.
interface bus_ram_emu_if;

  logic [15:0] addr;
  logic        rw_n;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        clk_en;
  logic        unmapped;

  modport master (
    output addr, rw_n, wr_data,
    input  rd_data, clk_en, unmapped
  );

  modport slave (
    input  addr, rw_n, wr_data,
    output rd_data, clk_en, unmapped
  );

endinterface

// File: rtl/bus_ram_emu_ram_sp.sv
// Single-port synchronous byte RAM, read-first, one clock read latency, no reset.
module ram_sp #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/bus_ram_emu.sv
// Slow asynchronous RAM emulator: stretches each CPU bus cycle via clk_en, maps RAM + vectors.
// Optional read/write statistics counters are enabled with `define BUS_RAM_EMU_STATS_EN.
module bus_ram_emu
  import bus_ram_pkg::*;
#(
  parameter int          RAM_ADDR_W  = 11,
  parameter int          WAIT_CYCLES = 3,
  parameter logic [15:0] NMI_VEC     = 16'h0000,
  parameter logic [15:0] RST_VEC     = 16'h0200,
  parameter logic [15:0] IRQ_VEC     = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  bus_ram_emu_if.slave       bus,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
);

  localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  wait_q;
  logic        clk_en_q;
  logic        unmapped_q;
  logic [7:0]  rd_hold_q;
  logic [15:0] addr_q;
  logic        rw_n_q;
  logic [7:0]  wr_data_q;
  logic [15:0] src_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  done_data;
  logic        ram_we;

  function automatic logic is_ram(input logic [15:0] a);
    return (a >> RAM_ADDR_W) == 16'h0000;
  endfunction

  function automatic logic is_vec(input logic [15:0] a);
    return a >= VEC_NMI_LO;
  endfunction

  function automatic logic [7:0] vec_byte(input logic [15:0] a);
    logic [15:0] v;
    if (a[15:1] == VEC_NMI_LO[15:1])      v = NMI_VEC;
    else if (a[15:1] == VEC_RST_LO[15:1]) v = RST_VEC;
    else                                  v = IRQ_VEC;
    return a[0] ? v[15:8] : v[7:0];
  endfunction

  // In LATCH the live bus address feeds the RAM and decode; afterwards the latched copy does.
  assign src_addr = (state_q == LATCH) ? bus.addr : addr_q;
  assign ram_we   = (state_q == DONE) && !rw_n_q && is_ram(addr_q);

  ram_sp #(
    .DEPTH  (2 ** RAM_ADDR_W),
    .ADDR_W (RAM_ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (src_addr[RAM_ADDR_W-1:0]),
    .wdata_i (wr_data_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    if (is_ram(addr_q))      done_data = ram_rdata;
    else if (is_vec(addr_q)) done_data = vec_byte(addr_q);
    else                     done_data = UNMAPPED_DATA;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LATCH:   state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
      WAIT:    if (wait_q == 4'd0) state_d = DONE;
      DONE:    state_d = LATCH;
      default: state_d = LATCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LATCH;
      wait_q     <= 4'd0;
      clk_en_q   <= 1'b0;
      unmapped_q <= 1'b0;
      rd_hold_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      clk_en_q   <= (state_d == DONE);
      unmapped_q <= (state_d == DONE) && !is_ram(src_addr) && !is_vec(src_addr);
      if (state_q == LATCH)
        wait_q <= WAIT_LD;
      else if (state_q == WAIT && wait_q != 4'd0)
        wait_q <= wait_q - 4'd1;
      if (state_q == DONE && rw_n_q)
        rd_hold_q <= done_data;
    end
  end

  // Bus payload is plain data: captured in LATCH only, no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == LATCH) begin
      addr_q    <= bus.addr;
      rw_n_q    <= bus.rw_n;
      wr_data_q <= bus.wr_data;
    end
  end

  assign bus.clk_en   = clk_en_q;
  assign bus.unmapped = unmapped_q;
  assign bus.rd_data  = (state_q == DONE && rw_n_q) ? done_data : rd_hold_q;

`ifdef BUS_RAM_EMU_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else if (state_q == DONE) begin
      if (rw_n_q) rd_cnt_q <= rd_cnt_q + 32'd1;
      else        wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_bus_ram_emu.sv
// Directed bench for bus_ram_emu: a WAIT_CYCLES=3 instance and a WAIT_CYCLES=0 instance.
module tb_bus_ram_emu;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst1;
  logic [31:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
  int          errors = 0;
  int          checks = 0;

  bus_ram_emu_if bi0 ();
  bus_ram_emu_if bi1 ();

  bus_ram_emu #(.WAIT_CYCLES(3)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .bus    (bi0.slave),
    .rd_cnt (rd_cnt0),
    .wr_cnt (wr_cnt0)
  );

  bus_ram_emu #(.WAIT_CYCLES(0)) dut1 (
    .clk    (clk),
    .rst    (rst1),
    .bus    (bi1.slave),
    .rd_cnt (rd_cnt1),
    .wr_cnt (wr_cnt1)
  );

  always #50 clk = ~clk;

  // Behaves like the CPU: drive the bus, wait for clk_en, then release after the enabling edge.
  task automatic bus_cycle(input int d, input logic [15:0] a, input logic rw,
                           input logic [7:0] wd, output logic [7:0] rd,
                           output int unm_n, output int ncyc);
    logic done;
    logic ce, u;
    logic [7:0] r;
    if (d == 0) begin
      bi0.addr = a; bi0.rw_n = rw; bi0.wr_data = wd;
    end else begin
      bi1.addr = a; bi1.rw_n = rw; bi1.wr_data = wd;
    end
    ncyc = 0; unm_n = 0; rd = 8'h00; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      ncyc++;
      if (d == 0) begin ce = bi0.clk_en; u = bi0.unmapped; r = bi0.rd_data; end
      else        begin ce = bi1.clk_en; u = bi1.unmapped; r = bi1.rd_data; end
      if (u === 1'b1) unm_n++;
      if (ce === 1'b1) begin
        rd = r;
        done = 1'b1;
      end else if (ncyc >= 40) begin
        checks++; errors++;
        $display("FAIL timeout addr=%h: clk_en not seen in %0d clocks (required within 40)", a, ncyc);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst1 = 1'b1;
    bi0.addr = 16'h0000; bi0.rw_n = 1'b1; bi0.wr_data = 8'h00;
    bi1.addr = 16'h0000; bi1.rw_n = 1'b1; bi1.wr_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bi0.clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got=%b want=0", bi0.clk_en); end
    checks++; if (bi0.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h want=00", bi0.rd_data); end
    checks++; if (bi0.unmapped !== 1'b0) begin errors++; $display("FAIL reset_unmapped got=%b want=0", bi0.unmapped); end
    checks++; if (rd_cnt0 !== 32'h0) begin errors++; $display("FAIL reset_rd_cnt got=%0d want=0", rd_cnt0); end
    checks++; if (wr_cnt0 !== 32'h0) begin errors++; $display("FAIL reset_wr_cnt got=%0d want=0", wr_cnt0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [7:0] rd; int u, n;
    bus_cycle(0, 16'hFFFC, 1'b1, 8'h00, rd, u, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL vec_lo_period got=%0d want=5", n); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL vec_lo_data got=%h want=00", rd); end
    checks++; if (u !== 0) begin errors++; $display("FAIL vec_lo_unmapped got=%0d want=0", u); end
    bus_cycle(0, 16'hFFFD, 1'b1, 8'h00, rd, u, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL vec_hi_period got=%0d want=5", n); end
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL vec_hi_data got=%h want=02", rd); end
  endtask

  task automatic test_ram_rw;
    logic [7:0] rd; int u, n;
    bus_cycle(0, 16'h0010, 1'b0, 8'hA5, rd, u, n);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL write_holds_rd got=%h want=02", rd); end
    checks++; if (u !== 0) begin errors++; $display("FAIL write_unmapped got=%0d want=0", u); end
    bus_cycle(0, 16'h0010, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL ram_read got=%h want=a5", rd); end
    checks++; if (u !== 0) begin errors++; $display("FAIL ram_read_unmapped got=%0d want=0", u); end
  endtask

  task automatic test_unmapped;
    logic [7:0] rd; int u, n;
    bus_cycle(0, 16'h0000, 1'b0, 8'h5A, rd, u, n);
    bus_cycle(0, 16'h4000, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL unmapped_read got=%h want=ff", rd); end
    checks++; if (u !== 1) begin errors++; $display("FAIL unmapped_pulse got=%0d clocks want=1", u); end
    bus_cycle(0, 16'h4000, 1'b0, 8'h11, rd, u, n);
    checks++; if (u !== 1) begin errors++; $display("FAIL unmapped_write_pulse got=%0d clocks want=1", u); end
    bus_cycle(0, 16'h0000, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL alias_unchanged got=%h want=5a", rd); end
    checks++; if (u !== 0) begin errors++; $display("FAIL alias_unmapped got=%0d want=0", u); end
  endtask

  task automatic test_vec_write;
    logic [7:0] rd; int u, n;
    bus_cycle(0, 16'hFFFC, 1'b0, 8'h55, rd, u, n);
    checks++; if (u !== 0) begin errors++; $display("FAIL vec_write_unmapped got=%0d want=0", u); end
    bus_cycle(0, 16'hFFFC, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL vec_write_dropped got=%h want=00", rd); end
  endtask

  task automatic test_reset_abort;
    logic [7:0] rd; int u, n;
    bus_cycle(0, 16'h0020, 1'b0, 8'h77, rd, u, n);
    bi0.addr = 16'h0020; bi0.rw_n = 1'b0; bi0.wr_data = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bi0.clk_en !== 1'b0) begin errors++; $display("FAIL abort_clk_en got=%b want=0", bi0.clk_en); end
    checks++; if (bi0.rd_data !== 8'h00) begin errors++; $display("FAIL abort_rd_data got=%h want=00", bi0.rd_data); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (bi0.clk_en !== 1'b0) begin errors++; $display("FAIL abort_hold_clk_en got=%b want=0", bi0.clk_en); end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_cycle(0, 16'h0020, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'h77) begin errors++; $display("FAIL abort_no_commit got=%h want=77", rd); end
  endtask

  task automatic test_zero_wait;
    logic [7:0] rd; int u, n;
    logic [31:0] exp_rd, exp_wr;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    bus_cycle(1, 16'h0030, 1'b0, 8'hC3, rd, u, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL zw_period got=%0d want=2", n); end
    bus_cycle(1, 16'h0030, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL zw_read got=%h want=c3", rd); end
    checks++; if (n !== 2) begin errors++; $display("FAIL zw_read_period got=%0d want=2", n); end
    bus_cycle(1, 16'h0031, 1'b0, 8'h3C, rd, u, n);
    bus_cycle(1, 16'h0031, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL zw_read2 got=%h want=3c", rd); end
    bus_cycle(1, 16'hFFFD, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL zw_vec got=%h want=02", rd); end
    bus_cycle(1, 16'h5000, 1'b1, 8'h00, rd, u, n);
    checks++; if (rd !== 8'hFF || u !== 1) begin errors++; $display("FAIL zw_unmapped got=%h/%0d want=ff/1", rd, u); end
`ifdef BUS_RAM_EMU_STATS_EN
    exp_rd = 32'd4; exp_wr = 32'd2;
`else
    exp_rd = 32'd0; exp_wr = 32'd0;
`endif
    checks++; if (rd_cnt1 !== exp_rd) begin errors++; $display("FAIL rd_cnt got=%0d want=%0d", rd_cnt1, exp_rd); end
    checks++; if (wr_cnt1 !== exp_wr) begin errors++; $display("FAIL wr_cnt got=%0d want=%0d", wr_cnt1, exp_wr); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ram_rw();
    test_unmapped();
    test_vec_write();
    test_reset_abort();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
